// File: rtl/mem_req_ctrl_pkg.sv
// mem_req_ctrl_pkg: shared types and constants for the SRAM request sequencer.
// Holds the controller state encoding, default geometry of the 16x1024 macro,
// and the width of the optional statistics counters.
package mem_req_ctrl_pkg;

  // Controller states; the encoding is also visible on the dbg_state output.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_RD_LAT = 1;
  localparam int STAT_W     = 16;

endpackage

// File: rtl/mem_req_ctrl_sat_cnt.sv
// mem_req_ctrl_sat_cnt: up-counter that sticks at all-ones instead of wrapping.
// Synchronous active-high reset clears it.
module mem_req_ctrl_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Count one per i_inc pulse, holding once the maximum value is reached.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: one-at-a-time request sequencer in front of the single-port
// SRAM macro wrapper.
//
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are high; valid, once raised by this block, is held with stable data
// until that edge, and ready never depends combinationally on valid.
//
// Optional feature macro: MEM_REQ_CTRL_STATS_EN adds the stat_rd_cnt and
// stat_wr_cnt outputs (saturating per-ISSUE read/write counters).
module mem_req_ctrl
  import mem_req_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_chip_en,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
`ifdef MEM_REQ_CTRL_STATS_EN
  output logic [STAT_W-1:0] stat_rd_cnt,
  output logic [STAT_W-1:0] stat_wr_cnt,
`endif
  output logic [1:0]        dbg_state
);

  // Counter value in the WAIT cycle during which the macro's read data is valid.
  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic              w_req_ready;
  logic              w_accept;
  logic              w_capture;
  logic              w_rsp_done;

  logic              r_write;
  logic [1:0]        r_cnt;
  logic              r_mem_chip_en;
  logic              r_mem_wr_en;
  logic              r_mem_rd_en;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wr_data;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode plus the per-cycle strobes the datapath acts on.
  always_comb begin
    w_next_state = r_state;
    w_req_ready  = 1'b0;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_rsp_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready = 1'b1;
        if (req_valid) begin
          w_accept     = 1'b1;
          w_next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_next_state = r_write ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (r_cnt == LAT_LAST) begin
          w_capture    = 1'b1;
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_rsp_done   = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Registered macro pins, latency counter and response channel. The enables
  // are loaded at the accept edge so they are high exactly during ISSUE.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_write       <= 1'b0;
      r_cnt         <= 2'd0;
      r_mem_chip_en <= 1'b0;
      r_mem_wr_en   <= 1'b0;
      r_mem_rd_en   <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wr_data <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
    end else begin
      r_mem_chip_en <= w_accept;
      r_mem_wr_en   <= w_accept & req_write;
      r_mem_rd_en   <= w_accept & ~req_write;
      if (w_accept) begin
        r_write    <= req_write;
        r_mem_addr <= req_addr;
      end
      // Write data only changes for writes so the pin keeps its last value.
      if (w_accept && req_write) begin
        r_mem_wr_data <= req_wdata;
      end
      if (r_state == ST_ISSUE) begin
        r_cnt <= 2'd0;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt + 2'd1;
      end
      if (w_capture) begin
        r_rsp_rdata <= mem_rd_data;
        r_rsp_valid <= 1'b1;
      end else if (w_rsp_done) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign req_ready   = w_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign mem_chip_en = r_mem_chip_en;
  assign mem_wr_en   = r_mem_wr_en;
  assign mem_rd_en   = r_mem_rd_en;
  assign mem_addr    = r_mem_addr;
  assign mem_wr_data = r_mem_wr_data;
  assign dbg_state   = r_state;

`ifdef MEM_REQ_CTRL_STATS_EN
  logic w_issue_rd;
  logic w_issue_wr;

  assign w_issue_rd = (r_state == ST_ISSUE) && !r_write;
  assign w_issue_wr = (r_state == ST_ISSUE) && r_write;

  mem_req_ctrl_sat_cnt #(.W(STAT_W)) u_stat_rd (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (w_issue_rd),
    .o_count (stat_rd_cnt)
  );

  mem_req_ctrl_sat_cnt #(.W(STAT_W)) u_stat_wr (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (w_issue_wr),
    .o_count (stat_wr_cnt)
  );
`endif

endmodule
